// File: rtl/axis_stim_pkg.sv
// Shared definitions for the AXI-Stream stimulus master: control-entry layout,
// FSM state encoding and the NBYTES-to-tkeep helper.
package axis_stim_pkg;

  localparam int CTRL_EOP        = 31;
  localparam int CTRL_TLAST      = 30;
  localparam int CTRL_GAP_LSB    = 16;
  localparam int CTRL_TUSER_LSB  = 8;
  localparam int CTRL_NBYTES_LSB = 0;
  localparam int CTRL_FIELD_W    = 8;
  localparam int MAX_KEEP_W      = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_GAP   = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // NBYTES of zero means a full beat; values at or above keep_w saturate to all ones.
  function automatic logic [MAX_KEEP_W-1:0] nbytes_to_keep(input logic [7:0] nbytes,
                                                           input int keep_w);
    logic [MAX_KEEP_W-1:0] keep;
    keep = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < keep_w && (nbytes == 8'd0 || i < int'(nbytes))) keep[i] = 1'b1;
    end
    return keep;
  endfunction

endpackage

// File: rtl/axis_stim_ram.sv
// Simple dual-port program RAM: one write port, one synchronous read-first read port.
module axis_stim_ram #(
  parameter int WIDTH      = 288,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: neither the array nor the read register is reset, so a program survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_stim_master.sv
// Self-sequencing AXI-Stream master that plays a loaded program of beats.
module axis_stim_master
  import axis_stim_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 13
`ifdef AXIS_STIM_INIT_FILE_EN
  ,
  parameter     INIT_CTRL_FILE = "",
  parameter     INIT_DATA_FILE = ""
`endif
) (
  input  logic                  tx_mac_aclk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_ctrl,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_err,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  loop_en,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           frame_cnt,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [7:0]            m_axis_tuser
);

  localparam int RAM_WIDTH = 32 + DATA_WIDTH;

  state_t                state;
  logic [RAM_WIDTH-1:0]  rd_word;
  logic [31:0]           ent_ctrl;
  logic [DATA_WIDTH-1:0] ent_data;
  logic [7:0]            ent_gap;
  logic [ADDR_WIDTH-1:0] cur_addr, base_addr, rd_addr;
  logic                  rd_en, wr_en, loop_q, stop_q, fresh, valid, xfer, finish;
  logic [7:0]            gap_cnt;
  logic                  reserved_unused;

  assign {ent_ctrl, ent_data} = rd_word;
  assign ent_gap         = ent_ctrl[CTRL_GAP_LSB +: CTRL_FIELD_W];
  assign reserved_unused = ^ent_ctrl[29:24];
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign wr_en           = ld_we && !busy;

  // The read register doubles as the beat register; a fresh entry with a gap is held back.
  assign valid  = (state == ST_SEND) && !(fresh && ent_gap != 8'd0);
  assign xfer   = valid && m_axis_tready;
  assign finish = (ent_ctrl[CTRL_TLAST] && stop_q) || (ent_ctrl[CTRL_EOP] && (!loop_q || stop_q));

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = cur_addr;
    if (state == ST_IDLE && start) begin
      rd_en   = 1'b1;
      rd_addr = start_addr;
    end else if (xfer && !finish) begin
      rd_en   = 1'b1;
      rd_addr = ent_ctrl[CTRL_EOP] ? base_addr : cur_addr + ADDR_WIDTH'(1);
    end
  end

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge tx_mac_aclk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      base_addr <= '0;
      loop_q    <= 1'b0;
      stop_q    <= 1'b0;
      fresh     <= 1'b0;
      gap_cnt   <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      ld_err    <= 1'b0;
    end else begin
      ld_err <= ld_we && busy;
      if (rd_en) cur_addr <= rd_addr;
      if (busy && stop) stop_q <= 1'b1;
      if (xfer) begin
        beat_cnt <= beat_cnt + 32'd1;
        if (ent_ctrl[CTRL_TLAST]) frame_cnt <= frame_cnt + 32'd1;
      end
      case (state)
        ST_IDLE: if (start) begin
          base_addr <= start_addr;
          loop_q    <= loop_en;
          stop_q    <= 1'b0;
          beat_cnt  <= '0;
          frame_cnt <= '0;
          state     <= ST_FETCH;
        end
        ST_FETCH: begin
          fresh <= 1'b0;
          if (ent_gap != 8'd0) begin
            gap_cnt <= ent_gap;
            state   <= ST_GAP;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) state <= ST_SEND;
        end
        ST_SEND: begin
          if (fresh && ent_gap != 8'd0) begin
            // This evaluation cycle is already the first idle cycle of the gap.
            fresh <= 1'b0;
            if (ent_gap != 8'd1) begin
              gap_cnt <= ent_gap - 8'd1;
              state   <= ST_GAP;
            end
          end else if (xfer) begin
            if (finish) state <= ST_DONE;
            else        fresh <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = valid;
  assign m_axis_tdata  = valid ? ent_data : '0;
  assign m_axis_tkeep  = valid ? KEEP_WIDTH'(nbytes_to_keep(ent_ctrl[CTRL_NBYTES_LSB +: CTRL_FIELD_W],
                                                            KEEP_WIDTH)) : '0;
  assign m_axis_tlast  = valid && ent_ctrl[CTRL_TLAST];
  assign m_axis_tuser  = valid ? ent_ctrl[CTRL_TUSER_LSB +: CTRL_FIELD_W] : '0;

  axis_stim_ram #(
    .WIDTH     (RAM_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (tx_mac_aclk),
    .wr_en  (wr_en),
    .wr_addr(ld_addr),
    .wr_data({ld_ctrl, ld_data}),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_word)
  );

endmodule

// File: tb/tb_axis_stim_master.sv
// Directed self-checking bench for axis_stim_master: sequencing, gaps, backpressure,
// tkeep, looping with stop, address wrap, load rejection, read-first and async reset.
module tb_axis_stim_master;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_we, ld_err, start, loop_en, stop, busy, done;
  logic [AW-1:0] ld_addr, start_addr;
  logic [31:0]   ld_ctrl, beat_cnt, frame_cnt;
  logic [DW-1:0] ld_data, tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tready, tlast;
  logic [7:0]    tuser;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axis_stim_master #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
    .tx_mac_aclk  (clk),
    .reset        (rst),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_ctrl      (ld_ctrl),
    .ld_data      (ld_data),
    .ld_err       (ld_err),
    .start        (start),
    .start_addr   (start_addr),
    .loop_en      (loop_en),
    .stop         (stop),
    .busy         (busy),
    .done         (done),
    .beat_cnt     (beat_cnt),
    .frame_cnt    (frame_cnt),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tlast (tlast),
    .m_axis_tuser (tuser)
  );

  function automatic logic [31:0] mk(input bit eop, input bit last, input logic [7:0] gap,
                                     input logic [7:0] user, input logic [7:0] nb);
    return {eop, last, 6'b0, gap, user, nb};
  endfunction

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16{3'b000, a}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] user, input bit last);
    check({tag, ".tvalid"}, tvalid, 1'b1);
    check({tag, ".tuser"}, tuser, user);
    check({tag, ".tlast"}, tlast, last);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] c, input logic [DW-1:0] d);
    ld_we = 1'b1; ld_addr = a; ld_ctrl = c; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  initial begin
    ld_we = 0; ld_addr = '0; ld_ctrl = '0; ld_data = '0;
    start = 0; start_addr = '0; loop_en = 0; stop = 0; tready = 1;

    // Reset values
    step(); step();
    check("rst.tvalid", tvalid, 0);
    check("rst.tdata", tdata, 0);
    check("rst.tkeep", tkeep, 0);
    check("rst.tlast", tlast, 0);
    check("rst.tuser", tuser, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ld_err", ld_err, 0);
    check("rst.beat_cnt", beat_cnt, 0);
    check("rst.frame_cnt", frame_cnt, 0);
    rst = 0;
    step();

    // Four back-to-back beats; NBYTES 0/0/40/5
    load(13'd0, mk(0, 0, 8'd0, 8'h11, 8'd0), pat(13'd0));
    check("t1.ld_err_idle", ld_err, 0);
    load(13'd1, mk(0, 0, 8'd0, 8'h12, 8'd0), pat(13'd1));
    load(13'd2, mk(0, 0, 8'd0, 8'h13, 8'd40), pat(13'd2));
    load(13'd3, mk(1, 1, 8'd0, 8'h14, 8'd5), pat(13'd3));
    start = 1; start_addr = 13'd0; loop_en = 0;
    step();
    start = 0;
    check("t1.fetch_tvalid", tvalid, 0);
    check("t1.busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_beat("t1.beat", 8'h11 + 8'(i), (i == 3));
      check("t1.tdata", tdata, pat(AW'(i)));
      check("t1.tkeep", tkeep, (i == 3) ? 32'h0000_001F : 32'hFFFF_FFFF);
      check("t1.beat_cnt", beat_cnt, 32'(i));
    end
    step();
    check("t1.done", done, 1);
    check("t1.done_tvalid", tvalid, 0);
    check("t1.beat_cnt_end", beat_cnt, 4);
    check("t1.frame_cnt_end", frame_cnt, 1);
    step();
    check("t1.done_pulse", done, 0);
    check("t1.busy_end", busy, 0);

    // GAP=5 on the first entry, then 10 cycles of backpressure on entry 1
    load(13'd0, mk(0, 0, 8'd5, 8'h21, 8'd0), pat(13'd0));
    start = 1; start_addr = 13'd0;
    step();
    start = 0;
    for (int i = 0; i < 6; i++) begin
      check("t2.gap_idle", tvalid, 0);
      step();
    end
    check_beat("t2.first", 8'h21, 0);
    check("t2.tdata0", tdata, pat(13'd0));
    step();
    tready = 0;
    check_beat("t2.held", 8'h12, 0);
    check("t2.beat_cnt_pre", beat_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2.stall_tvalid", tvalid, 1);
      check("t2.stall_tdata", tdata, pat(13'd1));
      check("t2.stall_tuser", tuser, 8'h12);
      check("t2.stall_beat_cnt", beat_cnt, 1);
    end
    tready = 1;
    step();
    check_beat("t2.after", 8'h13, 0);
    check("t2.beat_cnt_after", beat_cnt, 2);
    step();
    check_beat("t2.last", 8'h14, 1);
    step();
    check("t2.done", done, 1);
    check("t2.beat_cnt_end", beat_cnt, 4);
    check("t2.frame_cnt_end", frame_cnt, 1);
    step();

    // Looping 2-frame program with a 2-cycle gap; stop during frame 3
    load(13'd16, mk(0, 0, 8'd0, 8'h31, 8'd0), pat(13'd16));
    load(13'd17, mk(0, 1, 8'd2, 8'h32, 8'd0), pat(13'd17));
    load(13'd18, mk(0, 0, 8'd0, 8'h33, 8'd0), pat(13'd18));
    load(13'd19, mk(1, 1, 8'd0, 8'h34, 8'd0), pat(13'd19));
    start = 1; start_addr = 13'd16; loop_en = 1;
    step();
    start = 0; loop_en = 0;
    step(); check_beat("t3.f1a", 8'h31, 0);
    step(); check("t3.gap1", tvalid, 0);
    step(); check("t3.gap2", tvalid, 0);
    step(); check_beat("t3.f1b", 8'h32, 1);
    step(); check_beat("t3.f2a", 8'h33, 0);
    step(); check_beat("t3.f2b", 8'h34, 1);
    step(); check_beat("t3.f3a", 8'h31, 0);
    stop = 1;
    step();
    stop = 0;
    check("t3.gap3", tvalid, 0);
    step(); check("t3.gap4", tvalid, 0);
    step(); check_beat("t3.f3b", 8'h32, 1);
    step();
    check("t3.done", done, 1);
    check("t3.done_tvalid", tvalid, 0);
    check("t3.frame_cnt", frame_cnt, 3);
    check("t3.beat_cnt", beat_cnt, 6);
    step();
    check("t3.idle", busy, 0);

    // Address wrap 8190 -> 1; write while busy is rejected
    load(13'd8190, mk(0, 0, 8'd0, 8'h41, 8'd0), pat(13'd8190));
    load(13'd8191, mk(0, 0, 8'd0, 8'h42, 8'd0), pat(13'd8191));
    load(13'd0,    mk(0, 0, 8'd0, 8'h43, 8'd0), pat(13'd0));
    load(13'd1,    mk(1, 1, 8'd0, 8'h44, 8'd0), pat(13'd1));
    start = 1; start_addr = 13'd8190;
    step();
    start = 0;
    ld_we = 1; ld_addr = 13'd1; ld_ctrl = mk(0, 0, 8'd0, 8'h99, 8'd0); ld_data = '0;
    step();
    ld_we = 0;
    check("t4.ld_err", ld_err, 1);
    check_beat("t4.a8190", 8'h41, 0);
    check("t4.tdata8190", tdata, pat(13'd8190));
    step();
    check("t4.ld_err_pulse", ld_err, 0);
    check_beat("t4.a8191", 8'h42, 0);
    step();
    check_beat("t4.a0", 8'h43, 0);
    check("t4.tdata0", tdata, pat(13'd0));
    step();
    check_beat("t4.a1_unchanged", 8'h44, 1);
    step();
    check("t4.done", done, 1);
    check("t4.beat_cnt", beat_cnt, 4);
    step();

    // Simultaneous start and write to the same address: old data is played
    ld_we = 1; ld_addr = 13'd0; ld_ctrl = mk(1, 1, 8'd0, 8'h55, 8'd0); ld_data = pat(13'd5);
    start = 1; start_addr = 13'd0;
    step();
    ld_we = 0; start = 0;
    step(); check_beat("t5.old", 8'h43, 0);
    step(); check_beat("t5.next", 8'h44, 1);
    step(); check("t5.done", done, 1);
    step();
    start = 1;
    step();
    start = 0;
    step();
    check_beat("t5.new", 8'h55, 1);
    check("t5.new_tdata", tdata, pat(13'd5));
    step(); check("t5.done2", done, 1);
    step();

    // Reset while a beat is stalled in SEND
    tready = 0; start = 1; start_addr = 13'd0;
    step();
    start = 0;
    step();
    check("t6.pre_tvalid", tvalid, 1);
    #2 rst = 1;
    #1;
    check("t6.tvalid", tvalid, 0);
    check("t6.tdata", tdata, 0);
    check("t6.tlast", tlast, 0);
    check("t6.tuser", tuser, 0);
    check("t6.tkeep", tkeep, 0);
    check("t6.busy", busy, 0);
    check("t6.beat_cnt", beat_cnt, 0);
    step();
    rst = 0; tready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6.no_done", done, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
